// File: rtl/alu_pkg.sv
// alu_pkg: ALU opcode encodings, datapath width and operand helpers shared by the ALU sharing logic.
package alu_pkg;
    localparam int DATA_W = 32;
    localparam logic [7:0] ALU_ADD  = 8'h01;
    localparam logic [7:0] ALU_SLL  = 8'h02;
    localparam logic [7:0] ALU_SLT  = 8'h04;
    localparam logic [7:0] ALU_SLTU = 8'h08;
    localparam logic [7:0] ALU_XOR  = 8'h10;
    localparam logic [7:0] ALU_SRL  = 8'h20;
    localparam logic [7:0] ALU_OR   = 8'h40;
    localparam logic [7:0] ALU_AND  = 8'h80;
    // Two's complement negate; 32'h8000_0000 wraps onto itself by design.
    function automatic logic [DATA_W-1:0] negate(input logic [DATA_W-1:0] v);
        return ~v + 1'b1;
    endfunction
endpackage

// File: rtl/alu_share_ctrl_rr_arbiter.sv
// rr_arbiter: round-robin arbiter scanning from a rotating pointer; the pointer moves past each winner.
module rr_arbiter #(
    parameter int N = 2,
    parameter int W = (N > 1) ? $clog2(N) : 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] req,
    input  logic         en,
    output logic [N-1:0] grant,
    output logic [W-1:0] idx,
    output logic [W-1:0] ptr
);
    logic found;
    always_comb begin
        found = 1'b0;
        idx = '0;
        for (int i = 0; i < N; i++) begin
            if (!found && req[(int'(ptr) + i) % N]) begin
                found = 1'b1;
                idx = W'((int'(ptr) + i) % N);
            end
        end
        grant = (en && found) ? ({{(N-1){1'b0}}, 1'b1} << idx) : '0;
    end
    always_ff @(posedge clk) begin
        if (rst) ptr <= '0;
        else if (en && found) ptr <= (idx == W'(N-1)) ? '0 : idx + 1'b1;
    end
endmodule

// File: rtl/alu_share_ctrl.sv
// alu_share_ctrl: shares one combinational ALU among NREQ requesters through an issue and a result register.
import alu_pkg::*;
module alu_share_ctrl #(
    parameter int NREQ = 2,
    parameter int ID_W = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic [NREQ-1:0]        req_valid_i,
    output logic [NREQ-1:0]        req_ready_o,
    input  logic [NREQ*DATA_W-1:0] req_op1_i,
    input  logic [NREQ*DATA_W-1:0] req_op2_i,
    input  logic [NREQ*8-1:0]      req_opcode_i,
    input  logic [NREQ-1:0]        req_sub_i,
    output logic [DATA_W-1:0]      alu_op1_o,
    output logic [DATA_W-1:0]      alu_op2_o,
    output logic [7:0]             alu_opcode_o,
    input  logic [DATA_W-1:0]      alu_res_i,
    output logic                   rsp_valid_o,
    input  logic                   rsp_ready_i,
    output logic [DATA_W-1:0]      rsp_res_o,
    output logic [ID_W-1:0]        rsp_id_o
);
    logic              iss_valid;
    logic [ID_W-1:0]   iss_id;
    logic [ID_W-1:0]   gnt_idx;
    logic [ID_W-1:0]   rr_ptr;
    logic              rsp_adv;
    logic              iss_adv;
    logic [DATA_W-1:0] sel_op1;
    logic [DATA_W-1:0] sel_op2;
    logic [7:0]        sel_opc;
    logic              sel_sub;
    assign rsp_adv = !rsp_valid_o || rsp_ready_i;
    assign iss_adv = !iss_valid || rsp_adv;
    assign sel_op1 = req_op1_i[int'(gnt_idx)*DATA_W +: DATA_W];
    assign sel_op2 = req_op2_i[int'(gnt_idx)*DATA_W +: DATA_W];
    assign sel_opc = req_opcode_i[int'(gnt_idx)*8 +: 8];
    assign sel_sub = req_sub_i[gnt_idx];
    rr_arbiter #(.N(NREQ), .W(ID_W)) u_arb (
        .clk   (clk_i),
        .rst   (rst_i),
        .req   (req_valid_i),
        .en    (iss_adv),
        .grant (req_ready_o),
        .idx   (gnt_idx),
        .ptr   (rr_ptr)
    );
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            iss_valid <= 1'b0;
            iss_id <= '0;
            alu_op1_o <= '0;
            alu_op2_o <= '0;
            alu_opcode_o <= '0;
            rsp_valid_o <= 1'b0;
            rsp_res_o <= '0;
            rsp_id_o <= '0;
        end else begin
            if (rsp_adv) begin
                rsp_valid_o <= iss_valid;
                if (iss_valid) begin
                    rsp_res_o <= alu_res_i;
                    rsp_id_o <= iss_id;
                end
            end
            // An empty issue slot presents opcode 0 so the ALU idles on a known value.
            if (iss_adv) begin
                iss_valid <= |req_valid_i;
                alu_opcode_o <= !(|req_valid_i) ? 8'h00 : sel_sub ? ALU_ADD : sel_opc;
                if (|req_valid_i) begin
                    iss_id <= gnt_idx;
                    alu_op1_o <= sel_op1;
                    alu_op2_o <= sel_sub ? negate(sel_op2) : sel_op2;
                end
            end
        end
    end
endmodule

// File: tb/tb_alu_share_ctrl.sv
// tb_alu_share_ctrl: scoreboard bench for alu_share_ctrl with a behavioural ALU attached to the issue stage.
module tb_alu_share_ctrl;
    import alu_pkg::*;
    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [31:0] op1_a [2];
    logic [31:0] op2_a [2];
    logic [7:0]  opc_a [2];
    logic [1:0]  sub_a;
    logic [31:0] alu_op1;
    logic [31:0] alu_op2;
    logic [31:0] alu_res;
    logic [31:0] rsp_res;
    logic [7:0]  alu_opcode;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [0:0]  rsp_id;
    int          n_chk = 0;
    int          n_fail = 0;
    int          rsp_cnt = 0;
    logic [32:0] sb [$];

    always #5 clk = ~clk;

    alu_share_ctrl #(.NREQ(2)) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .req_valid_i  (req_valid),
        .req_ready_o  (req_ready),
        .req_op1_i    ({op1_a[1], op1_a[0]}),
        .req_op2_i    ({op2_a[1], op2_a[0]}),
        .req_opcode_i ({opc_a[1], opc_a[0]}),
        .req_sub_i    (sub_a),
        .alu_op1_o    (alu_op1),
        .alu_op2_o    (alu_op2),
        .alu_opcode_o (alu_opcode),
        .alu_res_i    (alu_res),
        .rsp_valid_o  (rsp_valid),
        .rsp_ready_i  (rsp_ready),
        .rsp_res_o    (rsp_res),
        .rsp_id_o     (rsp_id)
    );

    function automatic logic [31:0] alu_fn(input logic [31:0] a, input logic [31:0] b, input logic [7:0] op);
        case (op)
            ALU_ADD:  return a + b;
            ALU_SLL:  return a << b[4:0];
            ALU_SLT:  return {31'b0, $signed(a) < $signed(b)};
            ALU_SLTU: return {31'b0, a < b};
            ALU_XOR:  return a ^ b;
            ALU_SRL:  return a >> b[4:0];
            ALU_OR:   return a | b;
            ALU_AND:  return a & b;
            default:  return 32'h0;
        endcase
    endfunction

    function automatic logic [31:0] exp_fn(input logic [31:0] a, input logic [31:0] b, input logic [7:0] op, input logic s);
        return s ? a - b : alu_fn(a, b, op);
    endfunction

    assign alu_res = alu_fn(alu_op1, alu_op2, alu_opcode);

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic monitor();
        logic [32:0] e;
        forever begin
            @(negedge clk);
            if (rst) sb.delete();
            else begin
                for (int k = 0; k < 2; k++)
                    if (req_valid[k] && req_ready[k]) sb.push_back({exp_fn(op1_a[k], op2_a[k], opc_a[k], sub_a[k]), 1'(k)});
                if (rsp_valid && rsp_ready) begin
                    n_chk++;
                    rsp_cnt++;
                    if (sb.size() == 0) begin
                        n_fail++;
                        $display("FAIL sb_unexpected: got res=%h id=%0d, required no response", rsp_res, rsp_id);
                    end else begin
                        e = sb.pop_front();
                        if ({rsp_res, rsp_id} !== e) begin
                            n_fail++;
                            $display("FAIL sb_result: got res=%h id=%0d, required res=%h id=%0d", rsp_res, rsp_id, e[32:1], e[0]);
                        end
                    end
                end
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) tick();
        @(negedge clk);
        n_chk++;
        if ({rsp_valid, alu_opcode, req_ready, alu_op1, alu_op2, rsp_res, rsp_id} !== '0) begin
            n_fail++;
            $display("FAIL reset_state: got v=%b opc=%h rdy=%b op1=%h op2=%h res=%h id=%0d, required all 0",
                     rsp_valid, alu_opcode, req_ready, alu_op1, alu_op2, rsp_res, rsp_id);
        end
        tick();
        rst = 1'b0;
    endtask

    task automatic test_single();
        tick();
        op1_a[0] = 5; op2_a[0] = 3; opc_a[0] = ALU_ADD; sub_a[0] = 1'b0; req_valid = 2'b01;
        @(negedge clk);
        n_chk++;
        if (req_ready !== 2'b01) begin n_fail++; $display("FAIL single_ready: got %b, required 01", req_ready); end
        tick();
        req_valid = 2'b00;
        @(negedge clk);
        n_chk++;
        if (rsp_valid !== 1'b0 || alu_opcode !== ALU_ADD) begin
            n_fail++; $display("FAIL single_issue: got v=%b opc=%h, required v=0 opc=01", rsp_valid, alu_opcode);
        end
        @(negedge clk);
        n_chk++;
        if ({rsp_valid, rsp_res, rsp_id} !== {1'b1, 32'd8, 1'b0}) begin
            n_fail++; $display("FAIL single_rsp: got v=%b res=%h id=%0d, required v=1 res=8 id=0", rsp_valid, rsp_res, rsp_id);
        end
    endtask

    task automatic test_sub();
        tick();
        op1_a[1] = 3; op2_a[1] = 5; opc_a[1] = ALU_XOR; sub_a[1] = 1'b1; req_valid = 2'b10;
        @(negedge clk);
        n_chk++;
        if (req_ready !== 2'b10) begin n_fail++; $display("FAIL sub_ready: got %b, required 10", req_ready); end
        tick();
        req_valid = 2'b00;
        @(negedge clk);
        n_chk++;
        if (alu_opcode !== 8'h01 || alu_op2 !== 32'hFFFF_FFFB) begin
            n_fail++; $display("FAIL sub_issue: got opc=%h op2=%h, required opc=01 op2=fffffffb", alu_opcode, alu_op2);
        end
        @(negedge clk);
        n_chk++;
        if ({rsp_valid, rsp_res, rsp_id} !== {1'b1, 32'hFFFF_FFFE, 1'b1}) begin
            n_fail++; $display("FAIL sub_rsp: got v=%b res=%h id=%0d, required v=1 res=fffffffe id=1", rsp_valid, rsp_res, rsp_id);
        end
    endtask

    task automatic test_fairness();
        int base;
        logic [1:0] exp;
        tick();
        op1_a[0] = 7; op2_a[0] = 2; opc_a[0] = ALU_XOR; sub_a[0] = 1'b0;
        op1_a[1] = 9; op2_a[1] = 4; opc_a[1] = ALU_AND; sub_a[1] = 1'b1;
        req_valid = 2'b11;
        base = rsp_cnt;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            exp = (c % 2 == 0) ? 2'b01 : 2'b10;
            n_chk++;
            if (req_ready !== exp) begin n_fail++; $display("FAIL fair_grant[%0d]: got %b, required %b", c, req_ready, exp); end
            if (c >= 2) begin
                n_chk++;
                if (rsp_valid !== 1'b1) begin n_fail++; $display("FAIL fair_rate[%0d]: got rsp_valid=%b, required 1", c, rsp_valid); end
            end
            tick();
        end
        req_valid = 2'b00;
        repeat (3) tick();
        n_chk++;
        if (rsp_cnt - base != 6 || sb.size() != 0) begin
            n_fail++; $display("FAIL fair_drain: got %0d responses, %0d pending, required 6 and 0", rsp_cnt - base, sb.size());
        end
    endtask

    task automatic test_back_pressure();
        int base;
        int n;
        logic was_ready;
        logic [31:0] held;
        tick();
        rsp_ready = 1'b0;
        n = 0;
        op1_a[0] = 10; op2_a[0] = 1; opc_a[0] = ALU_ADD; sub_a[0] = 1'b0; req_valid = 2'b01;
        base = rsp_cnt;
        held = '0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            was_ready = req_ready[0];
            n_chk++;
            if (was_ready !== (c < 2)) begin n_fail++; $display("FAIL bp_ready[%0d]: got %b, required %b", c, was_ready, c < 2); end
            if (c == 2) begin
                held = rsp_res;
                n_chk++;
                if (rsp_valid !== 1'b1 || rsp_res !== 32'd11) begin
                    n_fail++; $display("FAIL bp_first: got v=%b res=%h, required v=1 res=b", rsp_valid, rsp_res);
                end
            end else if (c > 2) begin
                n_chk++;
                if (rsp_res !== held || rsp_id !== 1'b0) begin
                    n_fail++; $display("FAIL bp_stable[%0d]: got res=%h id=%0d, required res=%h id=0", c, rsp_res, rsp_id, held);
                end
            end
            tick();
            if (was_ready) begin
                n++;
                op1_a[0] = 32'(10 * (n + 1)); op2_a[0] = 32'(n + 1);
            end
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        n_chk++;
        if (req_ready !== 2'b01) begin n_fail++; $display("FAIL bp_resume: got %b, required 01", req_ready); end
        tick();
        req_valid = 2'b00;
        repeat (4) tick();
        n_chk++;
        if (rsp_cnt - base != 3 || sb.size() != 0) begin
            n_fail++; $display("FAIL bp_drain: got %0d responses, %0d pending, required 3 and 0", rsp_cnt - base, sb.size());
        end
    endtask

    task automatic test_reset_mid();
        tick();
        rsp_ready = 1'b0;
        op1_a[0] = 40; op2_a[0] = 2; opc_a[0] = ALU_OR; sub_a[0] = 1'b0; req_valid = 2'b01;
        tick();
        op1_a[0] = 50;
        tick();
        req_valid = 2'b00;
        @(negedge clk);
        n_chk++;
        if (rsp_valid !== 1'b1 || alu_opcode !== ALU_OR) begin
            n_fail++; $display("FAIL rstmid_full: got v=%b opc=%h, required v=1 opc=40", rsp_valid, alu_opcode);
        end
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        n_chk++;
        if (rsp_valid !== 1'b0 || alu_opcode !== 8'h00 || req_ready !== 2'b00) begin
            n_fail++; $display("FAIL rstmid_clear: got v=%b opc=%h rdy=%b, required 0 00 00", rsp_valid, alu_opcode, req_ready);
        end
        tick();
        rsp_ready = 1'b1;
        op1_a[1] = 1; op2_a[1] = 1; opc_a[1] = ALU_SLL; sub_a[1] = 1'b0;
        req_valid = 2'b11;
        @(negedge clk);
        n_chk++;
        if (req_ready !== 2'b01) begin n_fail++; $display("FAIL rstmid_ptr: got %b, required 01", req_ready); end
        tick();
        req_valid = 2'b00;
        repeat (3) tick();
        n_chk++;
        if (sb.size() != 0) begin n_fail++; $display("FAIL rstmid_drain: got %0d pending, required 0", sb.size()); end
    endtask

    task automatic test_edge();
        tick();
        op1_a[0] = 0; op2_a[0] = 32'h8000_0000; opc_a[0] = ALU_XOR; sub_a[0] = 1'b1; req_valid = 2'b01;
        tick();
        req_valid = 2'b00;
        @(negedge clk);
        n_chk++;
        if (alu_op2 !== 32'h8000_0000 || alu_opcode !== 8'h01) begin
            n_fail++; $display("FAIL edge_neg_issue: got op2=%h opc=%h, required 80000000 01", alu_op2, alu_opcode);
        end
        @(negedge clk);
        n_chk++;
        if ({rsp_valid, rsp_res, rsp_id} !== {1'b1, 32'h8000_0000, 1'b0}) begin
            n_fail++; $display("FAIL edge_neg_rsp: got v=%b res=%h id=%0d, required 1 80000000 0", rsp_valid, rsp_res, rsp_id);
        end
        tick();
        op1_a[1] = 5; op2_a[1] = 6; opc_a[1] = 8'h00; sub_a[1] = 1'b0; req_valid = 2'b10;
        tick();
        req_valid = 2'b00;
        @(negedge clk);
        @(negedge clk);
        n_chk++;
        if ({rsp_valid, rsp_res, rsp_id} !== {1'b1, 32'h0, 1'b1}) begin
            n_fail++; $display("FAIL edge_zero_opc: got v=%b res=%h id=%0d, required 1 0 1", rsp_valid, rsp_res, rsp_id);
        end
        repeat (3) tick();
    endtask

    initial begin
        rst = 1'b1;
        req_valid = 2'b00;
        rsp_ready = 1'b1;
        sub_a = 2'b00;
        for (int k = 0; k < 2; k++) begin
            op1_a[k] = '0; op2_a[k] = '0; opc_a[k] = '0;
        end
        fork
            monitor();
        join_none
        test_reset();
        test_single();
        test_sub();
        test_fairness();
        test_back_pressure();
        test_reset_mid();
        test_edge();
        n_chk++;
        if (sb.size() != 0) begin n_fail++; $display("FAIL final_drain: got %0d pending, required 0", sb.size()); end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
